seg7_digit_collector: RTL and testbench
=======================================

# seg7_digit_collector

Receives a stream of 7-segment patterns, one digit per handshake, most-significant digit first. Decodes each pattern back to its 3-bit octal value and packs DIGITS values into one word. Delivers the word on a valid/ready output with an error flag. It is the receive-side counterpart of the team's binary-to-7-segment encoder and recovers operands or results from display-formatted traffic in the 8x8 multiplier datapath.

## Interface
- DIGITS, default 4: digits per word; legal range 1..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_seg  in  [0:6]  segment pattern; bit 0 = segment a … bit 6 = segment g.
- in_valid  in  1  in_seg is valid.
- in_ready  out  1  block accepts a digit this cycle.
- out_data  out  3*DIGITS  packed digits; the first digit received is in the top 3 bits.
- out_err  out  1  one or more digits in the word failed to decode.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  consumer accepts the word.

## Operation
- A digit is accepted on any cycle with in_valid && in_ready.
- Decode map (in_seg → value):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3
  - 0110011→4, 1011011→5, 1011111→6, 1110000→7
- Every other pattern, including the error glyph 1001111, decodes as value 000 and marks the digit invalid.
- Shift register: on accept, shift_reg ← {shift_reg[3*DIGITS-4:0], value}. The err accumulator ORs in the invalid bit.
- digit_cnt counts accepted digits, range 0..DIGITS-1.
- FSM, 2 states:
  - COLLECT: in_ready=1, out_valid=0. On accept with digit_cnt==DIGITS-1: load out_data from the shifted value and out_err from the accumulated error, clear digit_cnt and err_acc, go to HOLD. On any other accept: digit_cnt+1.
  - HOLD: in_ready=0, out_valid=1. out_data and out_err stay stable. On out_ready go to COLLECT.
- There is no bypass. In HOLD with out_ready=1, in_ready is still 0 that cycle. The next digit can be accepted on the following cycle.
- in_seg is ignored whenever in_valid=0 or in_ready=0.
- DIGITS=1: every accepted digit goes straight to HOLD.

## Timing
- Reset values:
  - state=COLLECT, digit_cnt=0, err_acc=0.
  - out_data=0, out_err=0, out_valid=0, in_ready=1 on the first cycle after reset release.
- Reset asserted mid-word or in HOLD discards the partial or pending word. Outputs return to reset values at the next edge.
- Latency: last digit accepted at edge N → out_valid=1 after edge N, and it stays high until the edge where out_ready=1.
- Throughput: DIGITS+1 cycles per word when out_ready is held high.
- in_ready and out_valid depend on state only, with no combinational path from in_valid or out_ready. out_valid is the complement of in_ready.
- The consumer may hold out_ready high continuously. The producer may hold in_valid high continuously, and digits are then taken only in COLLECT.

## Structure
- Package seg7_pkg holds the shared items:
  - localparams for the eight digit patterns SEG_0..SEG_7 and SEG_ERR (1001111), shared with the encoder.
  - The 1-bit state encoding (COLLECT=0, HOLD=1).
- Sub-module seg7_pattern_decode is combinational. It maps [0:6] pattern → [2:0] value plus hit. It is instantiated once and reusable elsewhere.
- Top level contains the FSM, digit_cnt, shift register, err_acc and output registers.

## Test plan
- Patterns 0110000, 1101101, 1111001, 1110000 (digits 1,2,3,7), DIGITS=4, out_ready=1 → one cycle after the 4th accept, out_valid=1, out_data=12'h29F, out_err=0.
- Second digit is 1001111, the others are 1111110 → out_data=12'h000, out_err=1; the next word is clean and reports out_err=0.
- Hold out_ready=0 for 5 cycles after a word completes → out_data/out_err stable and in_ready=0 throughout. Set out_ready=1 → in_ready=1 on the next cycle and digit 0 of the new word is accepted.
- in_valid toggling 1,0,1,0… with digits 4,5,6,0 → gaps ignored; out_data=12'h970 (100_101_110_000).
- Assert rst_n=0 for 1 cycle after 2 digits → restart with 7,7,7,7 gives out_data=12'hFFF. No residue of the first two digits appears.
- Run DIGITS=1 with the pattern sweep 0..7 → each accept produces a word equal to the digit, and each is followed by one HOLD cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment items: digit glyphs (bit 0 = segment a ... bit 6 = segment g)
// and the collector FSM state encoding.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [0:6] SEG_0   = 7'b1111110;
  localparam logic [0:6] SEG_1   = 7'b0110000;
  localparam logic [0:6] SEG_2   = 7'b1101101;
  localparam logic [0:6] SEG_3   = 7'b1111001;
  localparam logic [0:6] SEG_4   = 7'b0110011;
  localparam logic [0:6] SEG_5   = 7'b1011011;
  localparam logic [0:6] SEG_6   = 7'b1011111;
  localparam logic [0:6] SEG_7   = 7'b1110000;
  localparam logic [0:6] SEG_ERR = 7'b1001111;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to octal value decoder.
// Ports: seg [0:6] pattern in; value [2:0] decoded digit (0 on miss);
//        hit = 1 when seg is one of the eight digit glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic [2:0] value,
  output logic       hit
);

  always_comb begin
    value = 3'd0;
    hit   = 1'b1;
    case (seg)
      SEG_0:   value = 3'd0;
      SEG_1:   value = 3'd1;
      SEG_2:   value = 3'd2;
      SEG_3:   value = 3'd3;
      SEG_4:   value = 3'd4;
      SEG_5:   value = 3'd5;
      SEG_6:   value = 3'd6;
      SEG_7:   value = 3'd7;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_digit_collector.sv
// Collects DIGITS 7-segment patterns (MSD first) into one packed octal word.
// Ports: clk, rst_n (sync, active-low); in_seg/in_valid/in_ready digit input;
//        out_data (3*DIGITS, first digit on top), out_err, out_valid/out_ready.
module seg7_digit_collector
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:6]        in_seg,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3*DIGITS-1:0] out_data,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned W  = 3 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  state_t        state;
  logic [CW-1:0] digit_cnt;
  logic [W-1:0]  shift_reg;
  logic          err_acc;

  logic [2:0]    dec_value;
  logic          dec_hit;
  logic          accept;
  logic [W-1:0]  shifted;

  seg7_pattern_decode u_decode (
    .seg   (in_seg),
    .value (dec_value),
    .hit   (dec_hit)
  );

  // in_ready is a registered copy of (state == COLLECT), so no input-to-output path
  assign accept  = in_valid && in_ready;
  // Dropping the top 3 bits of the concatenation also works for DIGITS == 1
  assign shifted = W'({shift_reg, dec_value});

  // FSM, digit counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      digit_cnt <= '0;
      shift_reg <= '0;
      err_acc   <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (digit_cnt == LAST_CNT) begin
              out_data  <= shifted;
              out_err   <= err_acc | ~dec_hit;
              digit_cnt <= '0;
              err_acc   <= 1'b0;
              shift_reg <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
              shift_reg <= shifted;
              err_acc   <= err_acc | ~dec_hit;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_digit_collector.sv
// Directed self-checking bench: DIGITS=4 instance for word tests, DIGITS=1 for sweep.
module tb_seg7_digit_collector;
  import seg7_pkg::*;

  logic        clk;
  logic        rst_n;

  logic [0:6]  in_seg4;
  logic        in_valid4;
  logic        in_ready4;
  logic [11:0] out_data4;
  logic        out_err4;
  logic        out_valid4;
  logic        out_ready4;

  logic [0:6]  in_seg1;
  logic        in_valid1;
  logic        in_ready1;
  logic [2:0]  out_data1;
  logic        out_err1;
  logic        out_valid1;
  logic        out_ready1;

  int tests_run;
  int tests_failed;

  seg7_digit_collector #(.DIGITS(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_seg    (in_seg4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_err   (out_err4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
  );

  seg7_digit_collector #(.DIGITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_seg    (in_seg1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_data  (out_data1),
    .out_err   (out_err1),
    .out_valid (out_valid1),
    .out_ready (out_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one digit for one cycle on the DIGITS=4 instance
  task automatic send4(input logic [0:6] seg);
    in_valid4 = 1'b1;
    in_seg4   = seg;
    tick();
    in_valid4 = 1'b0;
  endtask

  initial begin
    logic [0:6] pats [8];
    pats = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7};
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    in_seg4    = SEG_0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    in_seg1    = SEG_0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", 32'(out_valid4), 32'h0);
    check("rst_ready", 32'(in_ready4), 32'h1);
    check("rst_data",  32'(out_data4), 32'h0);
    check("rst_err",   32'(out_err4), 32'h0);

    // Word 1,2,3,7
    send4(SEG_1);
    send4(SEG_2);
    send4(SEG_3);
    check("w1_not_yet", 32'(out_valid4), 32'h0);
    send4(SEG_7);
    check("w1_valid", 32'(out_valid4), 32'h1);
    check("w1_data",  32'(out_data4), 32'h29F);
    check("w1_err",   32'(out_err4), 32'h0);
    check("w1_ready", 32'(in_ready4), 32'h0);
    tick();
    check("w1_release_valid", 32'(out_valid4), 32'h0);
    check("w1_release_ready", 32'(in_ready4), 32'h1);

    // Error glyph in second position, then a clean word
    send4(SEG_0);
    send4(SEG_ERR);
    send4(SEG_0);
    send4(SEG_0);
    check("w2_valid", 32'(out_valid4), 32'h1);
    check("w2_data",  32'(out_data4), 32'h000);
    check("w2_err",   32'(out_err4), 32'h1);
    tick();
    send4(SEG_1);
    send4(SEG_1);
    send4(SEG_1);
    send4(SEG_1);
    check("w3_data", 32'(out_data4), 32'h249);
    check("w3_err",  32'(out_err4), 32'h0);
    tick();

    // Backpressure: hold out_ready low for 5 cycles with in_valid asserted
    out_ready4 = 1'b0;
    send4(SEG_7);
    send4(SEG_6);
    send4(SEG_5);
    send4(SEG_4);
    check("w4_valid", 32'(out_valid4), 32'h1);
    check("w4_data",  32'(out_data4), 32'hFAC);
    in_valid4 = 1'b1;
    in_seg4   = SEG_1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d_data", i),  32'(out_data4), 32'hFAC);
      check($sformatf("hold%0d_err", i),   32'(out_err4), 32'h0);
      check($sformatf("hold%0d_ready", i), 32'(in_ready4), 32'h0);
      check($sformatf("hold%0d_valid", i), 32'(out_valid4), 32'h1);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    check("hold_release_ready", 32'(in_ready4), 32'h1);
    check("hold_release_valid", 32'(out_valid4), 32'h0);
    send4(SEG_2);
    send4(SEG_3);
    send4(SEG_4);
    send4(SEG_5);
    check("w5_valid", 32'(out_valid4), 32'h1);
    check("w5_data",  32'(out_data4), 32'h4E5);
    tick();

    // Toggling in_valid: gaps carry a junk glyph that must be ignored
    send4(SEG_4);
    in_seg4 = SEG_7;
    tick();
    send4(SEG_5);
    in_seg4 = SEG_ERR;
    tick();
    send4(SEG_6);
    in_seg4 = SEG_3;
    tick();
    check("w6_gap_valid", 32'(out_valid4), 32'h0);
    send4(SEG_0);
    check("w6_valid", 32'(out_valid4), 32'h1);
    check("w6_data",  32'(out_data4), 32'h970);
    check("w6_err",   32'(out_err4), 32'h0);
    tick();

    // Reset mid-word discards the partial digits
    send4(SEG_3);
    send4(SEG_3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid4), 32'h0);
    check("mid_rst_ready", 32'(in_ready4), 32'h1);
    check("mid_rst_data",  32'(out_data4), 32'h0);
    send4(SEG_7);
    send4(SEG_7);
    check("w7_partial_valid", 32'(out_valid4), 32'h0);
    send4(SEG_7);
    send4(SEG_7);
    check("w7_valid", 32'(out_valid4), 32'h1);
    check("w7_data",  32'(out_data4), 32'hFFF);
    check("w7_err",   32'(out_err4), 32'h0);
    tick();

    // DIGITS=1 sweep with in_valid held high: accept, then one HOLD cycle
    in_valid1 = 1'b1;
    for (int d = 0; d < 8; d++) begin
      in_seg1 = pats[d];
      tick();
      check($sformatf("d1_%0d_valid", d), 32'(out_valid1), 32'h1);
      check($sformatf("d1_%0d_data", d),  32'(out_data1), 32'(d));
      check($sformatf("d1_%0d_err", d),   32'(out_err1), 32'h0);
      tick();
      check($sformatf("d1_%0d_hold", d),  32'(out_valid1), 32'h0);
      check($sformatf("d1_%0d_ready", d), 32'(in_ready1), 32'h1);
    end
    in_seg1 = SEG_ERR;
    tick();
    check("d1_err_valid", 32'(out_valid1), 32'h1);
    check("d1_err_data",  32'(out_data1), 32'h0);
    check("d1_err_err",   32'(out_err1), 32'h1);
    in_valid1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
